// File: rtl/seg_display_scanner_pkg.sv
// Shared definitions for the 7-segment scan controller: segment encoding
// and scan state machine encoding.
package seg_display_scanner_pkg;

  // Active-low segment vector: bit7 = a .. bit1 = g, bit0 = decimal point.
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'hFF;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_display_scanner_hexto7seg.sv
// Hex nibble to active-low 7-segment pattern; the decimal point bit is
// always returned dark and is replaced by the caller.
module seg_display_scanner_hexto7seg
  import seg_display_scanner_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  // lit[6] = a .. lit[0] = g, 1 = segment on
  logic [6:0] lit;

  always_comb begin
    lit = 7'b0000000;
    case (hex)
      4'h0: lit = 7'b1111110;
      4'h1: lit = 7'b0110000;
      4'h2: lit = 7'b1101101;
      4'h3: lit = 7'b1111001;
      4'h4: lit = 7'b0110011;
      4'h5: lit = 7'b1011011;
      4'h6: lit = 7'b1011111;
      4'h7: lit = 7'b1110000;
      4'h8: lit = 7'b1111111;
      4'h9: lit = 7'b1111011;
      4'hA: lit = 7'b1110111;
      4'hB: lit = 7'b0011111;
      4'hC: lit = 7'b1001110;
      4'hD: lit = 7'b0111101;
      4'hE: lit = 7'b1001111;
      4'hF: lit = 7'b1000111;
      default: lit = 7'b0000000;
    endcase

    seg         = SEG_BLANK;
    seg[SEG_A]  = ~lit[6];
    seg[SEG_B]  = ~lit[5];
    seg[SEG_C]  = ~lit[4];
    seg[SEG_D]  = ~lit[3];
    seg[SEG_E]  = ~lit[2];
    seg[SEG_F]  = ~lit[1];
    seg[SEG_G]  = ~lit[0];
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode 7-segment scan controller with a
// frame-aligned double-buffered load interface and per-slot blanking gap.
module seg_display_scanner
  import seg_display_scanner_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 12500,
  parameter int BLANK_TICKS     = 250
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [4*NUM_DIGITS-1:0]   load_value,
  input  logic [NUM_DIGITS-1:0]     load_dp,
  input  logic [NUM_DIGITS-1:0]     load_en,
  input  logic                      lz_suppress,
  output logic [NUM_DIGITS-1:0]     an,
  output seg_t                      seg,
  output logic                      frame_start
);

  localparam int CW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST       = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST       = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  scan_state_t             state;
  scan_state_t             state_next;

  logic [4*NUM_DIGITS-1:0] active_value;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [NUM_DIGITS-1:0]   active_en;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_en;
  logic                    pending;

  logic                    slot_wrap;
  logic                    frame_wrap;
  logic                    xfer;
  logic [3:0]              nibble;
  seg_t                    dec_seg;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    suppressed;
  logic [NUM_DIGITS-1:0]   drive_an;
  seg_t                    drive_seg;

  // Handshake: a word transfers on any cycle with load_valid && load_ready;
  // load_ready stays low while a transferred word waits for the frame
  // boundary, and the source must hold load_valid until it sees ready.
  assign load_ready = ~pending;
  assign xfer       = load_valid && load_ready;
  assign slot_wrap  = (cnt == CNT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_wrap) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BLANK:   if (cnt == CNT_BLANK_LAST) state_next = DRIVE;
      DRIVE:   if (slot_wrap)             state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // Commit happens only for words already pending before the wrap cycle,
  // so a word accepted on the wrap cycle waits a full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_value <= '0;
      active_dp    <= '0;
      active_en    <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_en    <= '0;
      pending      <= 1'b0;
    end else if (frame_wrap && pending) begin
      active_value <= shadow_value;
      active_dp    <= shadow_dp;
      active_en    <= shadow_en;
      pending      <= 1'b0;
    end else if (xfer) begin
      shadow_value <= load_value;
      shadow_dp    <= load_dp;
      shadow_en    <= load_en;
      pending      <= 1'b1;
    end
  end

  // upper_zero[i]: nibbles i..NUM_DIGITS-1 of the active value are all zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (active_value[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (active_value[4*i +: 4] == 4'h0);
    end
  end

  assign nibble     = active_value[{idx, 2'b00} +: 4];
  assign suppressed = !active_en[idx] ||
                      (lz_suppress && (idx != '0) && upper_zero[idx]);

  seg_display_scanner_hexto7seg u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  always_comb begin
    drive_an  = '1;
    drive_seg = SEG_BLANK;
    if (state == DRIVE && !suppressed) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        drive_an[i] = (IW'(i) != idx);
      end
      drive_seg         = dec_seg;
      drive_seg[SEG_DP] = ~active_dp[idx];
    end
  end

  // Anodes and segments change on the same edge, so a newly selected
  // anode never sees the previous digit's pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= '1;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      an          <= drive_an;
      seg         <= drive_seg;
      frame_start <= (state == BLANK) && (cnt == '0) && (idx == '0);
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner: expected per-cycle pin values of
// each committed frame are queued at load time and compared as frames play.
module tb_seg_display_scanner;

  localparam int N   = 8;
  localparam int TPD = 8;
  localparam int BT  = 2;
  localparam int FRAME = N * TPD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [4*N-1:0]  load_value = '0;
  logic [N-1:0]    load_dp = '0;
  logic [N-1:0]    load_en = '0;
  logic            lz_suppress = 1'b0;
  logic [N-1:0]    an;
  logic [7:0]      seg;
  logic            frame_start;

  int n_checks = 0;
  int n_fails  = 0;

  // {frame_start, an, seg} per pin cycle
  logic [16:0] exp_q[$];

  seg_display_scanner #(
    .NUM_DIGITS      (N),
    .TICKS_PER_DIGIT (TPD),
    .BLANK_TICKS     (BT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_value  (load_value),
    .load_dp     (load_dp),
    .load_en     (load_en),
    .lz_suppress (lz_suppress),
    .an          (an),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: return 8'h03;  4'h1: return 8'h9F;  4'h2: return 8'h25;  4'h3: return 8'h0D;
      4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1F;
      4'h8: return 8'h01;  4'h9: return 8'h09;  4'hA: return 8'h11;  4'hB: return 8'hC1;
      4'hC: return 8'h63;  4'hD: return 8'h85;  4'hE: return 8'h61;  default: return 8'h71;
    endcase
  endfunction

  task automatic push_frame(input logic [31:0] v, input logic [7:0] dp,
                            input logic [7:0] en, input logic lz);
    logic       dark;
    logic       fs;
    logic [7:0] a_e;
    logic [7:0] s_e;
    for (int d = 0; d < N; d++) begin
      dark = !en[d] || (lz && d != 0 && ((v >> (4 * d)) == 32'h0));
      for (int c = 0; c < TPD; c++) begin
        fs = (d == 0 && c == 0);
        if (c < BT || dark) begin
          a_e = 8'hFF;
          s_e = 8'hFF;
        end else begin
          a_e = ~(8'h01 << d);
          s_e = hex_seg(v[4*d +: 4]);
          s_e[0] = ~dp[d];
        end
        exp_q.push_back({fs, a_e, s_e});
      end
    end
  endtask

  task automatic check_frame(input string tag);
    logic [16:0] e;
    check({tag, " queue depth"}, 17'(exp_q.size()), 17'(FRAME));
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      e = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check(tag, {frame_start, an, seg}, e);
    end
    @(negedge clk);
    check({tag, " frame period"}, 17'(frame_start), 17'd1);
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 200);
    check("frame_start seen", 17'(frame_start), 17'd1);
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
    int n = 0;
    load_value = v;
    load_dp    = dp;
    load_en    = en;
    load_valid = 1'b1;
    while (!load_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready before load", 17'(load_ready), 17'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check("ready drops after transfer", 17'(load_ready), 17'd0);
  endtask

  task automatic wait_commit();
    int n = 0;
    while (!load_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready returns at commit", 17'(load_ready), 17'd1);
    @(negedge clk);
    check("frame_start after commit", 17'(frame_start), 17'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset an", 17'(an), 17'hFF);
    check("reset seg", 17'(seg), 17'hFF);
    check("reset ready", 17'(load_ready), 17'd1);
    check("reset frame_start", 17'(frame_start), 17'd0);
    rst_n = 1'b1;
    push_frame(32'h0, 8'h00, 8'h00, 1'b0);
    wait_fs();
    check_frame("dark after reset");

    // Plain hex display
    wait_fs();
    lz_suppress = 1'b0;
    do_load(32'h0123_4567, 8'h00, 8'hFF);
    push_frame(32'h0123_4567, 8'h00, 8'hFF, 1'b0);
    wait_commit();
    check_frame("hex 01234567");

    // Leading-zero suppression
    wait_fs();
    lz_suppress = 1'b1;
    do_load(32'h0000_00A5, 8'h00, 8'hFF);
    push_frame(32'h0000_00A5, 8'h00, 8'hFF, 1'b1);
    wait_commit();
    check_frame("lz 000000A5");

    // All-zero value keeps digit 0 lit
    wait_fs();
    do_load(32'h0, 8'h00, 8'hFF);
    push_frame(32'h0, 8'h00, 8'hFF, 1'b1);
    wait_commit();
    check_frame("lz zero");

    wait_fs();
    do_load(32'h0, 8'h01, 8'hFF);
    push_frame(32'h0, 8'h01, 8'hFF, 1'b1);
    wait_commit();
    check_frame("lz zero dp0");

    // Second offer while pending is ignored
    wait_fs();
    lz_suppress = 1'b0;
    do_load(32'h89AB_CDEF, 8'hA5, 8'hFF);
    push_frame(32'h89AB_CDEF, 8'hA5, 8'hFF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      load_value = 32'h1111_1111;
      load_dp    = 8'h00;
      load_en    = 8'hFF;
      load_valid = 1'b1;
      check("ready low while pending", 17'(load_ready), 17'd0);
    end
    @(negedge clk);
    load_valid = 1'b0;
    wait_commit();
    check_frame("pending ignore");

    // Digit enable mask
    wait_fs();
    do_load(32'hFEDC_BA98, 8'h00, 8'h0F);
    push_frame(32'hFEDC_BA98, 8'h00, 8'h0F, 1'b0);
    wait_commit();
    check_frame("en 0F");

    // Reset during DRIVE with a word pending
    wait_fs();
    repeat (3) @(negedge clk);
    check("drive before reset", 17'({an, seg}), 17'({8'hFE, 8'h01}));
    do_load(32'h2222_2222, 8'h00, 8'hFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset an", 17'(an), 17'hFF);
    check("async reset seg", 17'(seg), 17'hFF);
    check("async reset ready", 17'(load_ready), 17'd1);
    check("async reset frame_start", 17'(frame_start), 17'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_frame(32'h0, 8'h00, 8'h00, 1'b0);
    wait_fs();
    check_frame("dark after mid reset");
    check("ready idle after mid reset", 17'(load_ready), 17'd1);
    check("scoreboard drained", 17'(exp_q.size()), 17'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
